// File: rtl/fetch_decode_pipe_if.sv
// Fetch/decode bus: hazard and decode-stage controls in, fetch PC and IF/ID contents out.
interface fetch_decode_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stallF;
  logic             stallD;
  logic             pcsrcD;
  logic             jumpD;
  logic [31:0]      pcbranchD;
  logic [31:0]      instrF;
  logic [31:0]      pcF;
  logic [31:0]      instrD;
  logic [31:0]      pcplus4D;
  logic             validD;
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stallF, stallD, pcsrcD, jumpD, pcbranchD, instrF,
    input  pcF, instrD, pcplus4D, validD, rs_d, rt_d, stall_cnt, flush_cnt
  );

  modport slave (
    input  stallF, stallD, pcsrcD, jumpD, pcbranchD, instrF,
    output pcF, instrD, pcplus4D, validD, rs_d, rt_d, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// PC register, next-PC selection and IF/ID register of the 5-stage MIPS pipeline,
// with saturating stall/flush event counters.
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  fetch_decode_pipe_if.slave bus
);

  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      pcplus4_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [31:0]      pcplus4f;
  logic [31:0]      jump_tgt;
  logic [31:0]      pc_next;
  logic             redirect;

  // Branch/jump operands are only trusted once decode is not stalled.
  always_comb begin
    pcplus4f = pc_q + 32'd4;
    jump_tgt = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
    redirect = (bus.pcsrcD | bus.jumpD) & ~bus.stallD;
    pc_next  = pcplus4f;
    if (redirect && bus.jumpD) begin
      pc_next = jump_tgt;
    end else if (redirect && bus.pcsrcD) begin
      pc_next = bus.pcbranchD & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!bus.stallF) begin
      pc_q <= pc_next;
    end
  end

  // Redirect squashes the wrong-path fetch; stallF without stallD inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= 32'd0;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else if (bus.stallD) begin
      instr_q   <= instr_q;
      pcplus4_q <= pcplus4_q;
      valid_q   <= valid_q;
    end else if (redirect || bus.stallF) begin
      instr_q   <= 32'd0;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= bus.instrF;
      pcplus4_q <= pcplus4f;
      valid_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.stallD && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pcF       = pc_q;
  assign bus.instrD    = instr_q;
  assign bus.pcplus4D  = pcplus4_q;
  assign bus.validD    = valid_q;
  assign bus.rs_d      = instr_q[25:21];
  assign bus.rt_d      = instr_q[20:16];
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe: stimulus pushes expected state, a negedge monitor checks it.
module tb_fetch_decode_pipe;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_decode_pipe_if #(.CNT_W(CNT_W)) bus ();
  fetch_decode_pipe #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        cp4;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compare the registered state against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("pcF",       m.id, bus.pcF, m.pc);
      chk("instrD",    m.id, bus.instrD, m.ins);
      if (m.cp4) chk("pcplus4D", m.id, bus.pcplus4D, m.p4);
      chk("validD",    m.id, 32'(bus.validD), 32'(m.v));
      chk("rs_d",      m.id, 32'(bus.rs_d), 32'(m.ins[25:21]));
      chk("rt_d",      m.id, 32'(bus.rt_d), 32'(m.ins[20:16]));
      chk("stall_cnt", m.id, 32'(bus.stall_cnt), 32'(m.sc));
      chk("flush_cnt", m.id, 32'(bus.flush_cnt), 32'(m.fc));
    end
  end

  task automatic cyc(input logic r, input logic sf, input logic sd, input logic ps, input logic jp,
                     input logic [31:0] pcb, input logic [31:0] ins,
                     input logic [31:0] epc, input logic [31:0] eins, input logic [31:0] ep4,
                     input logic ev, input int esc, input int efc, input logic cp4);
    exp_t e;
    reset         = r;
    bus.stallF    = sf;
    bus.stallD    = sd;
    bus.pcsrcD    = ps;
    bus.jumpD     = jp;
    bus.pcbranchD = pcb;
    bus.instrF    = ins;
    @(posedge clk);
    #1;
    step_n++;
    e.id  = step_n;
    e.pc  = epc;
    e.ins = eins;
    e.p4  = ep4;
    e.v   = ev;
    e.sc  = 4'(esc);
    e.fc  = 4'(efc);
    e.cp4 = cp4;
    q.push_back(e);
  endtask

  initial begin
    // Reset held two cycles
    cyc(1,0,0,0,0, 32'h0, 32'h0,        32'h40, 32'h0, 32'h0, 0, 0, 0, 1);
    cyc(1,0,0,0,0, 32'h0, 32'h0,        32'h40, 32'h0, 32'h0, 0, 0, 0, 1);
    // First fetches
    cyc(0,0,0,0,0, 32'h0, 32'h8C080000, 32'h44, 32'h8C080000, 32'h44, 1, 0, 0, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h01095020, 32'h48, 32'h01095020, 32'h48, 1, 0, 0, 1);
    // Load-use stall holds everything, then resumes
    cyc(0,1,1,0,0, 32'h0, 32'hAAAA0000, 32'h48, 32'h01095020, 32'h48, 1, 1, 0, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h22220000, 32'h4C, 32'h22220000, 32'h4C, 1, 1, 0, 1);
    // Taken branch, low target bits forced to zero
    cyc(0,0,0,1,0, 32'h103, 32'h33330000, 32'h100, 32'h0, 32'h0, 0, 1, 1, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h44440000, 32'h104, 32'h44440000, 32'h104, 1, 1, 1, 1);
    // Branch during stallD ignored
    cyc(0,1,1,1,0, 32'h200, 32'hBBBB0000, 32'h104, 32'h44440000, 32'h104, 1, 2, 1, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h55550000, 32'h108, 32'h55550000, 32'h108, 1, 2, 1, 1);
    // stallF without stallD: PC held, bubble loaded, not a flush
    cyc(0,1,0,0,0, 32'h0, 32'h66660000, 32'h108, 32'h0, 32'h0, 0, 2, 1, 0);
    // Branch to 0x1000_0004, then a jump at that address
    cyc(0,0,0,1,0, 32'h10000004, 32'hCCCC0000, 32'h10000004, 32'h0, 32'h0, 0, 2, 2, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h08000010, 32'h10000008, 32'h08000010, 32'h10000008, 1, 2, 2, 1);
    // jumpD and pcsrcD together: jump wins
    cyc(0,0,0,1,1, 32'h300, 32'h77770000, 32'h10000040, 32'h0, 32'h0, 0, 2, 3, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h08000020, 32'h10000044, 32'h08000020, 32'h10000044, 1, 2, 3, 1);
    cyc(0,0,0,0,1, 32'h0, 32'h88880000, 32'h10000080, 32'h0, 32'h0, 0, 2, 4, 1);
    // PC wrap from 0xFFFF_FFFC to 0
    cyc(0,0,0,1,0, 32'hFFFFFFFF, 32'h99990000, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 2, 5, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h12340000, 32'h0, 32'h12340000, 32'h0, 1, 2, 5, 1);
    // Stall counter saturation
    for (int k = 1; k <= 20; k++) begin
      cyc(0,1,1,0,0, 32'h0, 32'hDEAD0000, 32'h0, 32'h12340000, 32'h0, 1,
          (2 + k > 15) ? 15 : 2 + k, 5, 1);
    end
    // Flush counter saturation
    for (int k = 1; k <= 12; k++) begin
      cyc(0,0,0,1,0, 32'h40, 32'hBEEF0000, 32'h40, 32'h0, 32'h0, 0, 15,
          (5 + k > 15) ? 15 : 5 + k, 1);
    end
    // Reset during a stalled branch wins, then restart
    cyc(1,1,1,1,0, 32'h500, 32'hFACE0000, 32'h40, 32'h0, 32'h0, 0, 0, 0, 1);
    cyc(0,0,0,0,0, 32'h0, 32'h8C080000, 32'h44, 32'h8C080000, 32'h44, 1, 0, 0, 1);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
